// File: rtl/pc_branch_unit_pkg.sv
// rtl/pc_branch_unit_pkg.sv - shared branch-sequencer state encoding and default sizes
package pc_branch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LATCH  = 2'b01,
    ST_DECIDE = 2'b10,
    ST_DONE   = 2'b11
  } br_state_t;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_OFFSET_W = 19;
  localparam logic [DEF_WIDTH-1:0] DEF_RESET_PC = '0;

endpackage

// File: rtl/pc_branch_unit_sign_extend.sv
// rtl/pc_branch_unit_sign_extend.sv - replicate the input MSB up to the output width
module pc_branch_unit_sign_extend #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  assign dout = {{(OUT_W - IN_W){din[IN_W-1]}}, din};

endmodule

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - program counter with fetch increment, bus load and conditional branch sequencer
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter int               OFFSET_W = DEF_OFFSET_W,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
  parameter int               PC_STEP  = 1,
  parameter int               CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                inc_pc,
  input  logic                pc_load,
  input  logic [WIDTH-1:0]    bus_in,
  input  logic                br_start,
  input  logic                br_always,
  input  logic [OFFSET_W-1:0] br_offset,
  input  logic                con_bit,
  output logic                con_en,
  output logic [WIDTH-1:0]    pc_out,
  output logic                br_busy,
  output logic                br_done,
  output logic                br_taken,
  output logic [CNT_W-1:0]    taken_cnt
);

  br_state_t        state, state_nxt;
  logic [WIDTH-1:0] off_ext;
  logic [WIDTH-1:0] off_q;
  logic [WIDTH-1:0] pc_q;
  logic             alw_q;
  logic             taken_q;
  logic             taken;
  logic [CNT_W-1:0] cnt_q;

  pc_branch_unit_sign_extend #(
    .IN_W  (OFFSET_W),
    .OUT_W (WIDTH)
  ) u_sext (
    .din  (br_offset),
    .dout (off_ext)
  );

  always_comb begin
    state_nxt = state;
    con_en    = 1'b0;
    case (state)
      ST_IDLE:   if (br_start) state_nxt = ST_LATCH;
      ST_LATCH: begin
        con_en    = 1'b1;
        state_nxt = ST_DECIDE;
      end
      ST_DECIDE: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // con_bit is only meaningful in DECIDE, after the flip-flop latched at the end of LATCH
  assign taken     = alw_q | con_bit;
  assign br_busy   = (state != ST_IDLE);
  assign br_done   = (state == ST_DONE);
  assign br_taken  = br_done & taken_q;
  assign pc_out    = pc_q;
  assign taken_cnt = cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      off_q   <= '0;
      alw_q   <= 1'b0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // a bus load overrides both the branch target and the fetch increment
      if (pc_load) begin
        pc_q <= bus_in;
      end else if (state == ST_DECIDE && taken) begin
        pc_q <= pc_q + off_q;
      end else if (state == ST_IDLE && inc_pc) begin
        pc_q <= pc_q + WIDTH'(PC_STEP);
      end

      if (state == ST_IDLE && br_start) begin
        off_q <= off_ext;
        alw_q <= br_always;
      end

      if (state == ST_DECIDE) begin
        taken_q <= taken;
        if (taken && cnt_q != {CNT_W{1'b1}}) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - directed stimulus with a cycle-timeline model of the branch unit
module tb_pc_branch_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        inc_pc = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] bus_in = '0;
  logic        br_start = 1'b0;
  logic        br_always = 1'b0;
  logic [18:0] br_offset = '0;
  logic        con_bit = 1'b0;

  logic        con_en, br_busy, br_done, br_taken;
  logic [31:0] pc_out;
  logic [15:0] taken_cnt;
  logic        con_en_s, br_busy_s, br_done_s, br_taken_s;
  logic [31:0] pc_out_s;
  logic [1:0]  taken_cnt_s;

  pc_branch_unit dut (
    .clock(clock), .reset_n(reset_n), .inc_pc(inc_pc), .pc_load(pc_load),
    .bus_in(bus_in), .br_start(br_start), .br_always(br_always),
    .br_offset(br_offset), .con_bit(con_bit), .con_en(con_en), .pc_out(pc_out),
    .br_busy(br_busy), .br_done(br_done), .br_taken(br_taken), .taken_cnt(taken_cnt)
  );

  pc_branch_unit #(.CNT_W(2)) dut_s (
    .clock(clock), .reset_n(reset_n), .inc_pc(inc_pc), .pc_load(pc_load),
    .bus_in(bus_in), .br_start(br_start), .br_always(br_always),
    .br_offset(br_offset), .con_bit(con_bit), .con_en(con_en_s), .pc_out(pc_out_s),
    .br_busy(br_busy_s), .br_done(br_done_s), .br_taken(br_taken_s), .taken_cnt(taken_cnt_s)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a branch is a timeline anchored at the cycle after br_start (LATCH = phase 0)
  logic [31:0] m_pc = '0;
  int          m_cnt = 0;
  bit          m_active = 0;
  int          m_cyc = 0;
  int          m_start = 0;
  logic [31:0] m_off = '0;
  bit          m_always = 0;
  bit          m_taken = 0;
  bit          was;
  int          ph;

  always @(posedge clock) begin
    if (!reset_n) begin
      m_pc = '0; m_cnt = 0; m_active = 0; m_taken = 0; m_cyc = 0; m_start = 0;
    end else begin
      was = m_active;
      ph  = m_cyc - m_start;
      if (pc_load) m_pc = bus_in;
      else if (was && ph == 1 && (m_always || con_bit)) m_pc = m_pc + m_off;
      else if (!was && inc_pc) m_pc = m_pc + 32'd1;
      if (was && ph == 1) begin
        m_taken = m_always || con_bit;
        if (m_taken) m_cnt++;
      end
      if (was && ph == 2) m_active = 0;
      if (!was && br_start) begin
        m_active = 1;
        m_start  = m_cyc + 1;
        m_off    = 32'($signed(br_offset));
        m_always = br_always;
      end
      m_cyc++;
    end
  end

  bit check_en = 0;
  int con_seen = 0;
  int done_seen = 0;
  bit last_taken = 0;

  always @(negedge clock) begin
    if (check_en) begin
      ph = m_cyc - m_start;
      chk("pc_out", pc_out, m_pc);
      chk("con_en", {31'd0, con_en}, {31'd0, m_active && ph == 0});
      chk("br_busy", {31'd0, br_busy}, {31'd0, m_active});
      chk("br_done", {31'd0, br_done}, {31'd0, m_active && ph == 2});
      chk("br_taken", {31'd0, br_taken}, {31'd0, m_active && ph == 2 && m_taken});
      chk("taken_cnt", {16'd0, taken_cnt}, (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
      chk("taken_cnt_sat2", {30'd0, taken_cnt_s}, (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
      chk("pc_out_s", pc_out_s, m_pc);
      if (con_en) con_seen++;
      if (br_done) begin
        done_seen++;
        last_taken = br_taken;
      end
    end
  end

  task automatic go(input bit inc, input bit load, input logic [31:0] bus,
                    input bit start, input bit alw, input logic [18:0] off);
    @(negedge clock);
    #1;
    inc_pc = inc; pc_load = load; bus_in = bus;
    br_start = start; br_always = alw; br_offset = off;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(0, 0, '0, 0, 0, '0);
  endtask

  task automatic load_pc(input logic [31:0] v);
    go(0, 1, v, 0, 0, '0);
    idle(1);
  endtask

  task automatic branch(input logic [18:0] off, input bit alw, input bit cb);
    con_bit = cb;
    go(0, 0, '0, 1, alw, off);
    idle(4);
  endtask

  int c0, d0;

  initial begin
    idle(3);
    reset_n = 1'b1;
    check_en = 1;
    idle(1);
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_cnt", {16'd0, taken_cnt}, 32'd0);

    for (int i = 0; i < 3; i++) go(1, 0, '0, 0, 0, '0);
    idle(1);
    chk("inc3_pc", pc_out, 32'h3);
    chk("inc3_no_con_en", con_seen, 0);

    load_pc(32'h10);
    branch(19'h00005, 0, 1);
    chk("taken_pc", pc_out, 32'h15);
    chk("taken_cnt1", {16'd0, taken_cnt}, 32'd1);
    chk("taken_con_en_once", con_seen, 1);
    chk("taken_flag", {31'd0, last_taken}, 32'd1);

    load_pc(32'h20);
    branch(19'h7FFFC, 0, 0);
    chk("nt_pc", pc_out, 32'h20);
    chk("nt_flag", {31'd0, last_taken}, 32'd0);
    chk("nt_done_count", done_seen, 2);

    branch(19'h7FFFC, 1, 0);
    chk("always_pc", pc_out, 32'h1C);

    load_pc(32'hFFFF_FFFE);
    branch(19'h00003, 0, 1);
    chk("wrap_br_pc", pc_out, 32'h1);
    load_pc(32'hFFFF_FFFF);
    go(1, 0, '0, 0, 0, '0);
    idle(1);
    chk("wrap_inc_pc", pc_out, 32'h0);

    c0 = con_seen;
    con_bit = 1;
    go(0, 0, '0, 1, 0, 19'h00005);
    go(1, 0, '0, 1, 0, 19'h00007);
    go(0, 1, 32'h100, 0, 0, '0);
    go(0, 0, '0, 1, 0, 19'h00009);
    idle(2);
    chk("prio_pc", pc_out, 32'h100);
    chk("prio_taken", {31'd0, last_taken}, 32'd1);
    chk("busy_no_second_con_en", con_seen, c0 + 1);
    chk("prio_cnt", {16'd0, taken_cnt}, 32'd4);

    load_pc(32'h40);
    con_bit = 1;
    go(1, 0, '0, 1, 0, 19'h00002);
    idle(4);
    chk("inc_start_pc", pc_out, 32'h43);
    chk("cnt5", {16'd0, taken_cnt}, 32'd5);
    chk("cnt_sat_small", {30'd0, taken_cnt_s}, 32'd3);

    load_pc(32'h50);
    d0 = done_seen;
    go(0, 0, '0, 1, 0, 19'h00004);
    idle(2);
    reset_n = 1'b0;
    #1;
    chk("midrst_pc", pc_out, 32'h0);
    chk("midrst_busy", {31'd0, br_busy}, 32'd0);
    chk("midrst_cnt", {16'd0, taken_cnt}, 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(3);
    chk("midrst_no_done", done_seen, d0);

    for (int i = 0; i < 5; i++) branch(19'h00001, 0, 1);
    chk("sat5_main", {16'd0, taken_cnt}, 32'd5);
    chk("sat5_small", {30'd0, taken_cnt_s}, 32'd3);
    chk("sat5_pc", pc_out, 32'h5);

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
